regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the register file's single write port (write_reg / write_data / regWrite) and shares it between two requesters, e.g. ALU writeback and load return.
- After reset or a reinit request, it first walks every register with its power-on value, then enters round-robin arbitration.
- Sits between the datapath writeback sources and register_file; read ports are not touched.

Parameters:
- NUM_REGS, 32, number of registers walked during init
- ADDR_W, 5, register address width; clog2(NUM_REGS)
- DATA_W, 32, data width
- INIT_SEED_COUNT, 8, registers 0..INIT_SEED_COUNT-1 initialise to index+1; all others initialise to 0

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- reinit  in  1  single-cycle pulse; requests a new init walk
- req0_valid  in  1  requester 0 write request
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready
- req1_valid / req1_addr / req1_data / req1_ready  same as requester 0, for requester 1
- rf_write_reg  out  ADDR_W  to register file write_reg
- rf_write_data  out  DATA_W  to register file write_data
- rf_regWrite  out  1  to register file regWrite
- init_done  out  1  high while in RUN

Behaviour:
- Reset (rst=0, asynchronous): state=INIT, init counter=0, rf_regWrite=0, rf_write_reg=0, rf_write_data=0, init_done=0, rr_last=1 (req0 favoured first), both readies 0.
- Write-port outputs are registered. A request accepted at edge N drives rf_* during cycle N+1 and lands in the register file at edge N+1. One-cycle latency, at most one write per cycle.
- INIT state:
  - One write per cycle: addr=counter, data=counter+1 if counter<INIT_SEED_COUNT, else 0.
  - Counter increments each cycle. After issuing addr NUM_REGS-1, go to RUN.
  - INIT lasts exactly NUM_REGS cycles. Both readies stay 0 throughout.
- RUN state: init_done=1. Readies are combinational from valids and rr_last:
  - only req0_valid -> req0_ready=1
  - only req1_valid -> req1_ready=1
  - both valid -> grant the requester other than rr_last
  - neither valid -> rf_regWrite=0 next cycle
  - rr_last updates only on a grant.
- Requesters hold valid, addr and data stable until ready. valid must not depend combinationally on ready.
- reinit in RUN:
  - Takes priority that cycle: both readies 0, no new grant.
  - A write already registered completes normally.
  - Next state is INIT with counter=0; init_done falls on the following edge.
- reinit during INIT restarts the counter at 0.
- Simultaneous writes to the same address are impossible by construction. Back-to-back grants to the same address are written in grant order.
- Address and data pass through unmodified. Counter width is ADDR_W+1 so the terminal compare does not wrap.
- rst asserted mid-walk or mid-write: all outputs clear immediately; after release the walk restarts from register 0.

Optional Feature:
- REGFILE_ARB_STATS_EN defined:
  - Adds outputs grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counts grants to its requester, saturating at 16'hFFFF. Init writes are not counted.
  - Both clear on rst and on reinit acceptance.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package regfile_pkg holds:
  - NUM_REGS, ADDR_W and DATA_W defaults
  - state typedef {INIT, RUN}
  - init value function (index -> seed value)
- Sub-module rr_arb2: 2-way round-robin arbiter. Inputs valid[1:0] and enable; outputs grant[1:0] (combinational) and rr_last (registered).
- Everything else stays in the top module.

Test Plan:
- Reset release, no requests:
  - rf_regWrite=1 for exactly 32 cycles, addresses 0..31.
  - Data 1..8 for regs 0..7, then 0.
  - init_done rises in cycle 33; register file reads reg 3 = 4.
- After init, req0 writes addr 9 data 0xDEADBEEF:
  - req0_ready=1 the same cycle.
  - Next cycle rf_write_reg=9, rf_write_data=0xDEADBEEF, rf_regWrite=1.
  - Reg 9 reads 0xDEADBEEF.
- Both valid continuously, 4 cycles, first cycle after init:
  - Grants in order req0, req1, req0, req1.
  - With REGFILE_ARB_STATS_EN: grant_cnt0=2, grant_cnt1=2.
- reinit pulsed while req1_valid=1:
  - req1_ready=0 that cycle.
  - A previously accepted write still appears.
  - init_done falls; a full 32-write walk follows; req1 is granted after init_done rises.
- rst dropped at init counter=15:
  - rf_regWrite=0 immediately.
  - After release, the walk restarts at addr 0 and takes a full 32 cycles.
- STATS build: force 65,540 req0 grants -> grant_cnt0 holds 0xFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, FSM state type and power-on seed function for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned RF_NUM_REGS        = 32;
  localparam int unsigned RF_ADDR_W          = 5;
  localparam int unsigned RF_DATA_W          = 32;
  localparam int unsigned RF_INIT_SEED_COUNT = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Power-on value of register idx: the first seed_count registers hold idx+1, the rest 0.
  function automatic logic [31:0] init_value(input int unsigned idx, input int unsigned seed_count);
    return (idx < seed_count) ? 32'(idx + 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-granted pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       rr_last
);

  logic rr_last_q, rr_last_d;
  logic [1:0] grant_c;

  // On contention the requester that was not granted last wins.
  always_comb begin
    grant_c = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = rr_last_q ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (grant_c[1]) begin
      rr_last_d = 1'b1;
    end else if (grant_c[0]) begin
      rr_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign grant   = grant_c;
  assign rr_last = rr_last_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: seeds every register after reset/reinit, then round-robins two requesters.
// Define REGFILE_ARB_STATS_EN to add saturating per-requester grant counters.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS        = RF_NUM_REGS,
  parameter int unsigned ADDR_W          = RF_ADDR_W,
  parameter int unsigned DATA_W          = RF_DATA_W,
  parameter int unsigned INIT_SEED_COUNT = RF_INIT_SEED_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reinit,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_regWrite,
`ifdef REGFILE_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  output logic              init_done
);

  // One extra bit so the terminal compare at NUM_REGS-1 never wraps.
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                init_done_q, init_done_d;
  logic [1:0]          grant;
  logic                arb_en;
  logic                rr_last_unused;

  assign arb_en = (state_q == RUN) && !reinit;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({req1_valid, req0_valid}),
    .enable  (arb_en),
    .grant   (grant),
    .rr_last (rr_last_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: if (!reinit && (cnt_q == CNT_W'(NUM_REGS - 1))) state_d = RUN;
      RUN:  if (reinit) state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  // Write-port and counter next values; the write port is registered for one-cycle latency.
  always_comb begin
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    init_done_d = (state_d == RUN);
    case (state_q)
      INIT: begin
        wr_en_d   = 1'b1;
        wr_reg_d  = cnt_q[ADDR_W-1:0];
        wr_data_d = DATA_W'(init_value(32'(cnt_q), INIT_SEED_COUNT));
        if (reinit || (cnt_q == CNT_W'(NUM_REGS - 1))) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (grant[0]) begin
          wr_en_d   = 1'b1;
          wr_reg_d  = req0_addr;
          wr_data_d = req0_data;
        end else if (grant[1]) begin
          wr_en_d   = 1'b1;
          wr_reg_d  = req1_addr;
          wr_data_d = req1_data;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign req0_ready    = grant[0];
  assign req1_ready    = grant[1];
  assign rf_regWrite   = wr_en_q;
  assign rf_write_reg  = wr_reg_q;
  assign rf_write_data = wr_data_q;
  assign init_done     = init_done_q;

`ifdef REGFILE_ARB_STATS_EN
  localparam int unsigned STAT_W = 16;

  logic [STAT_W-1:0] gcnt0_q, gcnt0_d;
  logic [STAT_W-1:0] gcnt1_q, gcnt1_d;

  // Saturating grant counters; reinit clears them along with restarting the walk.
  always_comb begin
    gcnt0_d = gcnt0_q;
    gcnt1_d = gcnt1_q;
    if (reinit) begin
      gcnt0_d = '0;
      gcnt1_d = '0;
    end else begin
      if (grant[0] && (gcnt0_q != {STAT_W{1'b1}})) gcnt0_d = gcnt0_q + STAT_W'(1);
      if (grant[1] && (gcnt1_q != {STAT_W{1'b1}})) gcnt1_d = gcnt1_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
    end
  end

  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: init walk, arbitration, reinit and mid-walk reset.
module tb_regfile_write_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        reinit;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_regWrite;
  logic        init_done;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
`endif

  int checks;
  int errors;
  wr_t exp_q[$];
  logic model_rr_last;
  logic tb_run;
  logic [31:0] rf_mem [32];

  regfile_write_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .reinit        (reinit),
    .req0_valid    (req0_valid),
    .req0_addr     (req0_addr),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_regWrite   (rf_regWrite),
`ifdef REGFILE_ARB_STATS_EN
    .grant_cnt0    (grant_cnt0),
    .grant_cnt1    (grant_cnt1),
`endif
    .init_done     (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model fed by the write port.
  always @(posedge clk) begin
    if (rst && rf_regWrite) rf_mem[rf_write_reg] <= rf_write_data;
  end

  // Scoreboard: every write seen on the port must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && rf_regWrite) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got reg=%0d data=%0h, required no write", rf_write_reg, rf_write_data);
      end else begin
        e = exp_q.pop_front();
        if (rf_write_reg !== e.addr || rf_write_data !== e.data) begin
          errors++;
          $display("FAIL write_port: got reg=%0d data=%0h, required reg=%0d data=%0h",
                   rf_write_reg, rf_write_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic push_init_walk();
    for (int i = 0; i < 32; i++) begin
      wr_t e;
      e.addr = 5'(i);
      e.data = (i < 8) ? 32'(i + 1) : 32'd0;
      exp_q.push_back(e);
    end
  endtask

  // Drive one cycle at posedge+1, compare readies against the model, advance to the next posedge+1.
  task automatic drive_cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                             input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                             input logic ri);
    logic e0, e1;
    wr_t e;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    reinit = ri;
    #1;
    e0 = tb_run && !ri && v0 && (!v1 || model_rr_last);
    e1 = tb_run && !ri && v1 && (!v0 || !model_rr_last);
    checks++;
    if (req0_ready !== e0) begin
      errors++;
      $display("FAIL req0_ready: got %b, required %b", req0_ready, e0);
    end
    checks++;
    if (req1_ready !== e1) begin
      errors++;
      $display("FAIL req1_ready: got %b, required %b", req1_ready, e1);
    end
    if (e0) begin
      e.addr = a0; e.data = d0; exp_q.push_back(e); model_rr_last = 1'b0;
    end else if (e1) begin
      e.addr = a1; e.data = d1; exp_q.push_back(e); model_rr_last = 1'b1;
    end
    @(posedge clk); #1;
    reinit = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d writes pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_walk_timing(input string name);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      checks++;
      if (init_done !== (k == 32)) begin
        errors++;
        $display("FAIL %s_init_done: edge %0d got %b, required %b", name, k, init_done, (k == 32));
      end
    end
    tb_run = 1'b1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #12;
    checks++;
    if ({rf_regWrite, rf_write_reg, rf_write_data, init_done, req0_ready, req1_ready} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b reg=%0d data=%0h done=%b rdy=%b%b, required all 0",
               rf_regWrite, rf_write_reg, rf_write_data, init_done, req1_ready, req0_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    push_init_walk();
    check_walk_timing("reset");
    checks++;
    if (rf_mem[3] !== 32'd4 || rf_mem[7] !== 32'd8 || rf_mem[8] !== 32'd0) begin
      errors++;
      $display("FAIL seed_values: got r3=%0h r7=%0h r8=%0h, required 4 8 0", rf_mem[3], rf_mem[7], rf_mem[8]);
    end
  endtask

  task automatic test_back_to_back();
    int i0 = 0;
    int i1 = 0;
    for (int n = 0; n < 4; n++) begin
      logic pick0;
      pick0 = model_rr_last;
      drive_cycle(1'b1, 5'(10 + i0), 32'hA000 + 32'(i0), 1'b1, 5'(20 + i1), 32'hB000 + 32'(i1), 1'b0);
      if (pick0) i0++; else i1++;
    end
`ifdef REGFILE_ARB_STATS_EN
    checks++;
    if (grant_cnt0 !== 16'd2 || grant_cnt1 !== 16'd2) begin
      errors++;
      $display("FAIL b2b_stats: got %0d/%0d, required 2/2", grant_cnt0, grant_cnt1);
    end
`endif
    wait_drain("b2b");
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    req0_valid = 1'b0;
    checks++;
    if (rf_regWrite !== 1'b1 || rf_write_reg !== 5'd9 || rf_write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_latency: got we=%b reg=%0d data=%0h, required 1 9 deadbeef",
               rf_regWrite, rf_write_reg, rf_write_data);
    end
    wait_drain("single");
    @(posedge clk); #1;
    checks++;
    if (rf_mem[9] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_landed: got %0h, required deadbeef", rf_mem[9]);
    end
  endtask

  task automatic test_reinit();
    drive_cycle(1'b1, 5'd20, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0);
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'hCAFE_F00D, 1'b1);
    tb_run = 1'b0;
    push_init_walk();
    for (int k = 1; k <= 32; k++) begin
      checks++;
      if (init_done !== 1'b0) begin
        errors++;
        $display("FAIL reinit_init_done: cycle %0d got %b, required 0", k, init_done);
      end
`ifdef REGFILE_ARB_STATS_EN
      if (k == 1) begin
        checks++;
        if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
          errors++;
          $display("FAIL reinit_stats_clear: got %0d/%0d, required 0/0", grant_cnt0, grant_cnt1);
        end
      end
`endif
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'hCAFE_F00D, 1'b0);
    end
    tb_run = 1'b1;
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL reinit_done_rise: got %b, required 1", init_done);
    end
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'hCAFE_F00D, 1'b0);
    wait_drain("reinit");
  endtask

  task automatic test_rst_midwalk();
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    tb_run = 1'b0;
    for (int i = 0; i < 14; i++) begin
      wr_t e;
      e.addr = 5'(i);
      e.data = (i < 8) ? 32'(i + 1) : 32'd0;
      exp_q.push_back(e);
    end
    repeat (15) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rf_regWrite !== 1'b0 || rf_write_reg !== 5'd0 || rf_write_data !== 32'd0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_midwalk_clear: got we=%b reg=%0d data=%0h done=%b, required all 0",
               rf_regWrite, rf_write_reg, rf_write_data, init_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_midwalk_progress: got %0d walk writes missing, required 0", exp_q.size());
      exp_q.delete();
    end
    model_rr_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    push_init_walk();
    check_walk_timing("rst_midwalk");
    wait_drain("rst_midwalk");
  endtask

`ifdef REGFILE_ARB_STATS_EN
  task automatic test_stats_saturate();
    checks++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL stats_after_rst: got %0d/%0d, required 0/0", grant_cnt0, grant_cnt1);
    end
    for (int i = 0; i < 65540; i++) begin
      drive_cycle(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'd0, 1'b0);
    end
    req0_valid = 1'b0;
    checks++;
    if (grant_cnt0 !== 16'hFFFF || grant_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL stats_saturate: got %0h/%0h, required ffff/0", grant_cnt0, grant_cnt1);
    end
    wait_drain("stats");
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    model_rr_last = 1'b1;
    tb_run = 1'b0;
    rst = 1'b0;
    reinit = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    test_reset();
    test_back_to_back();
    test_single();
    test_reinit();
    test_rst_midwalk();
`ifdef REGFILE_ARB_STATS_EN
    test_stats_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
